// File: rtl/lcd_text_driver_if.sv
// Host text/refresh handshake plus the HD44780 4-bit bus for lcd_text_driver.
// The driver connects through the slave modport and the host through the master modport.
interface lcd_text_driver_if #(
    parameter int ROWS = 2,
    parameter int COLS = 16
);
    logic [8*ROWS*COLS-1:0] strdata;
    logic                   refresh;
    logic                   busy;
    logic                   done;
    logic                   lcd_e;
    logic                   lcd_rs;
    logic                   lcd_rw;
    logic [3:0]             lcd_dat;

    modport master (
        output strdata, refresh,
        input  busy, done, lcd_e, lcd_rs, lcd_rw, lcd_dat
    );

    modport slave (
        input  strdata, refresh,
        output busy, done, lcd_e, lcd_rs, lcd_rw, lcd_dat
    );
endinterface

// File: rtl/lcd_text_driver.sv
// HD44780 4-bit text driver: power-up wait, init list, then full-screen redraws
// from a snapshot of strdata on refresh, pending request or text change.
module lcd_text_driver #(
    parameter int ROWS         = 2,
    parameter int COLS         = 16,
    parameter int T_EN         = 12,
    parameter int T_CMD        = 2000,
    parameter int T_CLR        = 82000,
    parameter int T_PWRUP      = 750000,
    parameter bit AUTO_REFRESH = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    lcd_text_driver_if.slave bus
);
    localparam int NCHAR = ROWS * COLS;
    localparam int TMAX0 = (T_PWRUP > T_CLR) ? T_PWRUP : T_CLR;
    localparam int TMAX1 = (T_CMD > T_EN) ? T_CMD : T_EN;
    localparam int TMAX  = (TMAX0 > TMAX1) ? TMAX0 : TMAX1;
    localparam int CW    = $clog2(TMAX + 1);
    localparam int CIW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RIW   = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [2:0] {S_PWRUP, S_INIT, S_IDLE, S_SETADDR, S_WRCHAR} state_t;
    typedef enum logic [2:0] {P_EH1, P_EL1, P_EH2, P_EL2, P_WAIT} phase_t;

    // Init steps 0..3 are lone nibbles, carried in the high half of the byte.
    function automatic logic [7:0] init_byte(input logic [2:0] step);
        case (step)
            3'd0, 3'd1, 3'd2: init_byte = 8'h30;
            3'd3:             init_byte = 8'h20;
            3'd4:             init_byte = 8'h28;
            3'd5:             init_byte = 8'h0C;
            3'd6:             init_byte = 8'h06;
            3'd7:             init_byte = 8'h01;
            default:          init_byte = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] row_cmd(input logic [RIW-1:0] row);
        case (int'(row))
            0:       row_cmd = 8'h80;
            1:       row_cmd = 8'hC0;
            2:       row_cmd = 8'h94;
            3:       row_cmd = 8'hD4;
            default: row_cmd = 8'h80;
        endcase
    endfunction

    function automatic logic [7:0] snap_char(input logic [8*NCHAR-1:0] snap,
                                             input logic [RIW-1:0] row,
                                             input logic [CIW-1:0] col);
        int k;
        k = int'(row) * COLS + int'(col);
        snap_char = snap[8*(NCHAR-1-k) +: 8];
    endfunction

    state_t             state_r, state_nxt_s;
    phase_t             phase_r, phase_nxt_s;
    logic [CW-1:0]      cnt_r, cnt_nxt_s, cnt_lim_s;
    logic [7:0]         byte_r, byte_nxt_s;
    logic               nib_only_r, nib_only_nxt_s;
    logic [2:0]         step_r, step_nxt_s;
    logic [RIW-1:0]     row_r, row_nxt_s;
    logic [CIW-1:0]     col_r, col_nxt_s;
    logic [8*NCHAR-1:0] snap_r, snap_nxt_s;
    logic               pending_r, pending_nxt_s;
    logic               lcd_e_r, lcd_e_nxt_s;
    logic               lcd_rs_r, lcd_rs_nxt_s;
    logic [3:0]         lcd_dat_r, lcd_dat_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               done_r, done_nxt_s;
    logic               cnt_last_s, xfer_end_s, start_s, xfer_nxt_s;

    // Phase length: enable half-periods, then the post-byte wait (longer after clear).
    always_comb begin
        cnt_lim_s = CW'(T_EN - 1);
        case (phase_r)
            P_WAIT:  cnt_lim_s = (state_r == S_INIT && step_r == 3'd7) ? CW'(T_CLR - 1) : CW'(T_CMD - 1);
            default: cnt_lim_s = CW'(T_EN - 1);
        endcase
        cnt_last_s = (state_r == S_PWRUP) ? (cnt_r == CW'(T_PWRUP - 1)) : (cnt_r == cnt_lim_s);
        xfer_end_s = (phase_r == P_WAIT) && cnt_last_s;
        start_s    = bus.refresh || pending_r || (AUTO_REFRESH && (bus.strdata != snap_r));
    end

    // Next-state, sequencing and registered-output decode.
    always_comb begin
        state_nxt_s    = state_r;
        phase_nxt_s    = phase_r;
        cnt_nxt_s      = cnt_r;
        byte_nxt_s     = byte_r;
        nib_only_nxt_s = nib_only_r;
        step_nxt_s     = step_r;
        row_nxt_s      = row_r;
        col_nxt_s      = col_r;
        snap_nxt_s     = snap_r;
        pending_nxt_s  = pending_r;
        done_nxt_s     = 1'b0;

        if (state_r == S_IDLE) begin
            cnt_nxt_s = '0;
        end else if (cnt_last_s) begin
            cnt_nxt_s = '0;
            case (phase_r)
                P_EH1:   phase_nxt_s = P_EL1;
                P_EL1:   phase_nxt_s = nib_only_r ? P_WAIT : P_EH2;
                P_EH2:   phase_nxt_s = P_EL2;
                P_EL2:   phase_nxt_s = P_WAIT;
                default: phase_nxt_s = P_EH1;
            endcase
        end else begin
            cnt_nxt_s = cnt_r + CW'(1);
        end

        case (state_r)
            S_PWRUP: begin
                if (cnt_last_s) begin
                    state_nxt_s    = S_INIT;
                    step_nxt_s     = 3'd0;
                    byte_nxt_s     = init_byte(3'd0);
                    nib_only_nxt_s = 1'b1;
                    phase_nxt_s    = P_EH1;
                end else begin
                    phase_nxt_s = P_WAIT;
                end
            end
            S_INIT: begin
                if (xfer_end_s && step_r == 3'd7) begin
                    // The first frame after init is drawn unconditionally.
                    state_nxt_s   = S_IDLE;
                    pending_nxt_s = 1'b1;
                end else if (xfer_end_s) begin
                    step_nxt_s     = step_r + 3'd1;
                    byte_nxt_s     = init_byte(step_r + 3'd1);
                    nib_only_nxt_s = (step_r < 3'd3);
                end else begin
                    step_nxt_s = step_r;
                end
            end
            S_IDLE: begin
                if (start_s) begin
                    state_nxt_s    = S_SETADDR;
                    snap_nxt_s     = bus.strdata;
                    pending_nxt_s  = 1'b0;
                    row_nxt_s      = '0;
                    col_nxt_s      = '0;
                    byte_nxt_s     = row_cmd('0);
                    nib_only_nxt_s = 1'b0;
                    phase_nxt_s    = P_EH1;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_SETADDR: begin
                if (xfer_end_s) begin
                    state_nxt_s = S_WRCHAR;
                    col_nxt_s   = '0;
                    byte_nxt_s  = snap_char(snap_r, row_r, '0);
                end else begin
                    state_nxt_s = S_SETADDR;
                end
            end
            S_WRCHAR: begin
                if (xfer_end_s && col_r == CIW'(COLS - 1) && row_r == RIW'(ROWS - 1)) begin
                    state_nxt_s = S_IDLE;
                    done_nxt_s  = 1'b1;
                end else if (xfer_end_s && col_r == CIW'(COLS - 1)) begin
                    state_nxt_s = S_SETADDR;
                    row_nxt_s   = row_r + RIW'(1);
                    byte_nxt_s  = row_cmd(row_r + RIW'(1));
                end else if (xfer_end_s) begin
                    col_nxt_s  = col_r + CIW'(1);
                    byte_nxt_s = snap_char(snap_r, row_r, col_r + CIW'(1));
                end else begin
                    state_nxt_s = S_WRCHAR;
                end
            end
            default: state_nxt_s = S_PWRUP;
        endcase

        if (bus.refresh && state_r != S_IDLE) begin
            pending_nxt_s = 1'b1;
        end else begin
            pending_nxt_s = pending_nxt_s;
        end

        xfer_nxt_s   = (state_nxt_s == S_INIT) || (state_nxt_s == S_SETADDR) || (state_nxt_s == S_WRCHAR);
        lcd_e_nxt_s  = xfer_nxt_s && ((phase_nxt_s == P_EH1) || (phase_nxt_s == P_EH2));
        lcd_rs_nxt_s = (state_nxt_s == S_WRCHAR);
        busy_nxt_s   = (state_nxt_s != S_IDLE);
        if (!xfer_nxt_s) begin
            lcd_dat_nxt_s = 4'h0;
        end else if (phase_nxt_s == P_EH1 || phase_nxt_s == P_EL1) begin
            lcd_dat_nxt_s = byte_nxt_s[7:4];
        end else if (phase_nxt_s == P_EH2 || phase_nxt_s == P_EL2) begin
            lcd_dat_nxt_s = byte_nxt_s[3:0];
        end else begin
            lcd_dat_nxt_s = lcd_dat_r;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_PWRUP;
            phase_r    <= P_WAIT;
            cnt_r      <= '0;
            byte_r     <= 8'h00;
            nib_only_r <= 1'b0;
            step_r     <= 3'd0;
            row_r      <= '0;
            col_r      <= '0;
            snap_r     <= {NCHAR{8'h20}};
            pending_r  <= 1'b0;
            lcd_e_r    <= 1'b0;
            lcd_rs_r   <= 1'b0;
            lcd_dat_r  <= 4'h0;
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            phase_r    <= phase_nxt_s;
            cnt_r      <= cnt_nxt_s;
            byte_r     <= byte_nxt_s;
            nib_only_r <= nib_only_nxt_s;
            step_r     <= step_nxt_s;
            row_r      <= row_nxt_s;
            col_r      <= col_nxt_s;
            snap_r     <= snap_nxt_s;
            pending_r  <= pending_nxt_s;
            lcd_e_r    <= lcd_e_nxt_s;
            lcd_rs_r   <= lcd_rs_nxt_s;
            lcd_dat_r  <= lcd_dat_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
        end
    end

    assign bus.lcd_e   = lcd_e_r;
    assign bus.lcd_rs  = lcd_rs_r;
    assign bus.lcd_rw  = 1'b0;
    assign bus.lcd_dat = lcd_dat_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
endmodule
